// File: rtl/countdown_timer_pkg.sv
// Shared constants for the loadable down-counter: FSM state encoding and default width.
package countdown_timer_pkg;

    typedef logic cdt_state_t;

    localparam cdt_state_t ST_IDLE  = 1'b0;
    localparam cdt_state_t ST_ARMED = 1'b1;

    localparam int CDT_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter that flags terminal count, with one-shot or auto-reload operation.
// Latency: load visible one edge later; expire is a registered pulse in the cycle after the terminal edge.
// Backpressure: none; enable=0 freezes the count, and a load always wins over a decrement.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = CDT_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count_out,
    output logic             running,
    output logic             expire
);

    cdt_state_t       state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expire_q, expire_d;
    logic             terminal;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    // ARMED guarantees count_q >= 1, so the decrement below can never wrap.
    assign terminal = (count_q == WIDTH'(1));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;
        if (load_en) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != '0) ? ST_ARMED : ST_IDLE;
        end else if (state_q == ST_ARMED && enable) begin
            if (terminal) begin
                expire_d = 1'b1;
                if (auto_reload && reload_q != '0) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_comb begin
        running   = (state_q == ST_ARMED);
        count_out = count_q;
        expire    = expire_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer (WIDTH=4) with hand-computed expected sequences.
module tb_countdown_timer;

    localparam int W = 4;

    logic         clock;
    logic         reset;
    logic         load_en;
    logic [W-1:0] load_value;
    logic         enable;
    logic         auto_reload;
    logic [W-1:0] count_out;
    logic         running;
    logic         expire;

    int n_tests = 0;
    int n_fail  = 0;

    countdown_timer #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_en     (load_en),
        .load_value  (load_value),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count_out   (count_out),
        .running     (running),
        .expire      (expire)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input int cnt, input bit run, input bit exp_pulse);
        check({tag, ".count"},   32'(count_out), 32'(cnt));
        check({tag, ".running"}, 32'(running),   32'(run));
        check({tag, ".expire"},  32'(expire),    32'(exp_pulse));
    endtask

    task automatic do_load(input logic [W-1:0] val);
        load_en    = 1'b1;
        load_value = val;
        step();
        load_en    = 1'b0;
    endtask

    initial begin
        int exp_cnt [7];
        bit exp_exp [7];

        reset       = 1'b1;
        load_en     = 1'b0;
        load_value  = '0;
        enable      = 1'b0;
        auto_reload = 1'b0;

        // 1. reset, immediate and edge-free
        #2 reset = 1'b0;
        #1 check_state("rst_init", 0, 0, 0);
        step();
        reset = 1'b1;
        do_load(4'd9);
        check_state("pre_rst_load", 9, 1, 0);
        #2 reset = 1'b0;
        #1 check_state("rst_async", 0, 0, 0);
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_state($sformatf("rst_idle%0d", i), 0, 0, 0);
        end

        // 2. one-shot 5 -> 0
        do_load(4'd5);
        check_state("os_load", 5, 1, 0);
        for (int c = 4; c >= 1; c--) begin
            step();
            check_state($sformatf("os_cnt%0d", c), c, 1, 0);
        end
        step();
        check_state("os_term", 0, 0, 1);
        step();
        check_state("os_after", 0, 0, 0);

        // 3. pause
        enable = 1'b0;
        do_load(4'd3);
        check_state("pz_load", 3, 1, 0);
        enable = 1'b1;
        step();
        check_state("pz_dec", 2, 1, 0);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_state($sformatf("pz_hold%0d", i), 2, 1, 0);
        end
        enable = 1'b1;
        step();
        check_state("pz_one", 1, 1, 0);
        step();
        check_state("pz_term", 0, 0, 1);
        step();
        check_state("pz_after", 0, 0, 0);

        // 4. auto-reload, then drop auto_reload before the last terminal edge
        auto_reload = 1'b1;
        do_load(4'd3);
        check_state("ar_load", 3, 1, 0);
        exp_cnt = '{2, 1, 3, 2, 1, 3, 2};
        exp_exp = '{0, 0, 1, 0, 0, 1, 0};
        for (int i = 0; i < 7; i++) begin
            step();
            check_state($sformatf("ar_seq%0d", i), exp_cnt[i], 1, exp_exp[i]);
        end
        auto_reload = 1'b0;
        step();
        check_state("ar_one", 1, 1, 0);
        step();
        check_state("ar_end", 0, 0, 1);
        step();
        check_state("ar_after", 0, 0, 0);

        // 5a. load at count==1 suppresses expiry
        do_load(4'd2);
        step();
        check_state("col_one", 1, 1, 0);
        do_load(4'd7);
        check_state("col_load7", 7, 1, 0);
        step();
        check_state("col_dec", 6, 1, 0);
        // 5b. load zero while counting
        do_load(4'd0);
        check_state("col_load0", 0, 0, 0);
        step();
        check_state("col_idle", 0, 0, 0);
        // 5c. maximum load counts the full range
        do_load(4'd15);
        check_state("max_load", 15, 1, 0);
        for (int c = 14; c >= 1; c--) begin
            step();
            check_state($sformatf("max_cnt%0d", c), c, 1, 0);
        end
        step();
        check_state("max_term", 0, 0, 1);
        step();
        check_state("max_after", 0, 0, 0);

        // 6. async reset mid-count, then no activity without a fresh load
        do_load(4'd9);
        for (int i = 0; i < 3; i++) step();
        check_state("mr_six", 6, 1, 0);
        #2 reset = 1'b0;
        #1 check_state("mr_async", 0, 0, 0);
        reset       = 1'b1;
        auto_reload = 1'b1;
        enable      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_state($sformatf("mr_idle%0d", i), 0, 0, 0);
        end
        do_load(4'd2);
        check_state("mr_reload", 2, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter with terminal-count detection, one-shot and auto-reload modes.
- Counterpart to the team's up-counter: it counts a programmed value down to zero and flags expiry, rather than counting up from zero.
- Used as a programmable delay or period generator beside the up-counter in lab designs.
- Single clock domain.

Parameters:
- WIDTH, 4, width of load_value and count_out; legal range WIDTH >= 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- load_en  input  1  load strobe; sampled on the rising clock edge.
- load_value  input  WIDTH  start and reload value, captured when load_en=1.
- enable  input  1  count enable; decrement permitted only when 1.
- auto_reload  input  1  1 = reload on expiry; 0 = one-shot. Sampled at the expiry edge.
- count_out  output  WIDTH  current count, registered.
- running  output  1  1 while the FSM is in ARMED.
- expire  output  1  one-cycle pulse marking terminal count, registered.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - reset=0 forces count_out=0, reload_reg=0, state=IDLE, running=0, expire=0 at once, with no clock edge needed.
  - Reset deassertion takes effect at the next rising edge.
- Internal registers: reload_reg (WIDTH bits) and a 1-bit FSM.
  - IDLE: count_out=0, nothing armed.
  - ARMED: count_out nonzero, counting when enabled.
- Priority per edge: reset > load_en > decrement > hold.
- Load (load_en=1), in any state:
  - count_out<=load_value and reload_reg<=load_value.
  - state<=ARMED if load_value!=0, else IDLE.
  - expire<=0. No decrement occurs that edge, even if enable=1 and count_out==1.
  - A load therefore suppresses a pending expiry.
- Decrement (ARMED, enable=1, load_en=0):
  - count_out>1: count_out<=count_out-1, expire<=0.
  - count_out==1 is the terminal edge. expire<=1 for exactly one cycle, then:
    - auto_reload=1 and reload_reg!=0: count_out<=reload_reg, stay ARMED. Period = reload_reg enabled cycles.
    - otherwise: count_out<=0, state<=IDLE.
- Hold (ARMED, enable=0): count_out and state unchanged, expire<=0.
- IDLE with load_en=0: enable and auto_reload are ignored; count_out stays 0 and expire stays 0.
- Arithmetic and output timing:
  - Unsigned arithmetic; no underflow path exists, because ARMED implies count_out>=1.
  - expire is high for exactly the one cycle after the terminal edge and never two consecutive cycles unless reload_reg==1 with auto_reload=1, where it stays high continuously.
  - running is a registered function of state: 1 in ARMED, 0 in IDLE.
- Maximum load: 2^WIDTH-1 is legal and counts the full range.

Decomposition:
- Shared package countdown_timer_pkg holds:
  - state encoding localparams ST_IDLE=1'b0 and ST_ARMED=1'b1;
  - default WIDTH constant.
- No sub-module. The terminal-count compare (count_out==1) is inline logic.

Test Plan:
1. Reset: drive reset=0 mid-cycle with no edge -> count_out=0, running=0, expire=0 immediately. Release, raise enable=1 with no load -> count_out stays 0 and running stays 0 for 10 cycles.
2. One-shot, WIDTH=4: load_value=5, load_en pulse, enable=1, auto_reload=0 -> count_out reads 5,4,3,2,1,0 on consecutive edges; expire=1 only in the cycle count_out reads 0; running falls that same cycle.
3. Pause: load 3, enable=1 for one edge -> count_out=2; enable=0 for 4 edges -> count_out holds at 2 and expire=0; enable=1 -> 1, then 0 with a single expire pulse.
4. Auto-reload: load 3, auto_reload=1, enable=1 -> count_out sequence 3,2,1,3,2,1,3; expire pulses every 3 cycles. Drop auto_reload before the next terminal edge -> sequence ends 2,1,0, enters IDLE, final expire pulse.
5. Load collisions:
   - At count_out==1 with enable=1, load_en with load_value=7 -> count_out=7 and no expire.
   - Load 0 -> IDLE, running=0, no expire.
   - Load 15 (max) -> 15 decrements to 0, one expire pulse.
6. Async reset mid-count: at count_out=6 in ARMED, pulse reset low between edges -> count_out=0 and running=0 before the next edge. After release, auto_reload=1 and enable=1 alone produce no activity until a fresh load.
